// File: rtl/ntt_seq_core.sv
// ntt_seq_core: sequential N-point number-theoretic transform.
// out[i] = sum_j a[j]*w^(i*j) mod q, computed with one modular multiply-accumulate per cycle.
// Optional inverse mode (inv/w_inv/n_inv ports plus a per-row scaling cycle) is
// compiled in when the macro NTT_INVERSE_EN is defined.
module ntt_seq_core #(
  parameter int N     = 16,
  parameter int LOG_N = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_data,
  input  logic [CW-1:0] q,
  input  logic [CW-1:0] w,
`ifdef NTT_INVERSE_EN
  input  logic          inv,
  input  logic [CW-1:0] w_inv,
  input  logic [CW-1:0] n_inv,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          cfg_err
);

  // FLUSH is the single cycle between the last MAC and the first result beat.
  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_FLUSH, S_OUTPUT} state_t;

  localparam int PW = 2 * CW;
  localparam int SW = 2 * CW + 1;
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  state_t state_q, state_d;
  logic [LOG_N-1:0] j_q, j_d, i_q, i_d, k_q, k_d;
  logic [CW-1:0] a_q [N];
  logic [CW-1:0] a_d [N];
  logic [CW-1:0] res_q [N];
  logic [CW-1:0] res_d [N];
  logic [CW-1:0] q_r_q, q_r_d, w_r_q, w_r_d;
  logic [CW-1:0] t_q, t_d, p_q, p_d, acc_q, acc_d;
  logic          cfg_err_q, cfg_err_d;
`ifdef NTT_INVERSE_EN
  logic          inv_q, inv_d, scale_q, scale_d;
  logic [CW-1:0] n_inv_q, n_inv_d;
`endif

  logic [PW-1:0] mac_prod;
  logic [SW-1:0] mac_sum;
  logic [CW-1:0] mac_acc;
  logic          row_end;
  logic [CW-1:0] row_val;

  // A modulus below 2 is a configuration error; return 0 rather than dividing by 0 or 1.
  function automatic logic [CW-1:0] reduce_mod(input logic [SW-1:0] x, input logic [CW-1:0] m);
    logic [SW-1:0] r;
    r = '0;
    if (m >= CW'(2)) r = x % SW'(m);
    return r[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] mul_mod(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                            input logic [CW-1:0] m);
    logic [PW-1:0] prod;
    prod = PW'(x) * PW'(y);
    return reduce_mod(SW'(prod), m);
  endfunction

  // One modular MAC: column 0 restarts the accumulator, later columns add a[j]*p.
  always_comb begin
    mac_prod = PW'(a_q[j_q]) * PW'(p_q);
    mac_sum  = SW'(acc_q) + SW'(mac_prod);
    if (j_q == '0) mac_acc = reduce_mod(SW'(a_q[0]), q_r_q);
    else           mac_acc = reduce_mod(mac_sum, q_r_q);
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    i_d       = i_q;
    k_d       = k_q;
    a_d       = a_q;
    res_d     = res_q;
    q_r_d     = q_r_q;
    w_r_d     = w_r_q;
    t_d       = t_q;
    p_d       = p_q;
    acc_d     = acc_q;
    cfg_err_d = cfg_err_q;
`ifdef NTT_INVERSE_EN
    inv_d     = inv_q;
    scale_d   = scale_q;
    n_inv_d   = n_inv_q;
`endif
    row_end   = 1'b0;
    row_val   = mac_acc;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d[j_q] = in_data;
          j_d      = j_q + LOG_N'(1);
          if (j_q == '0) begin
            q_r_d     = q;
            cfg_err_d = (q < CW'(2));
            w_r_d     = reduce_mod(SW'(w), q);
`ifdef NTT_INVERSE_EN
            inv_d   = inv;
            n_inv_d = n_inv;
            if (inv) w_r_d = reduce_mod(SW'(w_inv), q);
`endif
          end
          if (j_q == LAST) begin
            state_d = S_COMPUTE;
            j_d     = '0;
            i_d     = '0;
            t_d     = reduce_mod(SW'(1), q_r_q);
          end
        end
      end

      S_COMPUTE: begin
        busy = 1'b1;
`ifdef NTT_INVERSE_EN
        if (scale_q) begin
          scale_d = 1'b0;
          row_end = 1'b1;
          row_val = mul_mod(acc_q, n_inv_q, q_r_q);
        end else
`endif
        begin
          acc_d = mac_acc;
          p_d   = (j_q == '0) ? t_q : mul_mod(p_q, t_q, q_r_q);
          if (j_q == LAST) begin
`ifdef NTT_INVERSE_EN
            if (inv_q) scale_d = 1'b1;
            else       row_end = 1'b1;
`else
            row_end = 1'b1;
`endif
          end else begin
            j_d = j_q + LOG_N'(1);
          end
        end
        if (row_end) begin
          res_d[i_q] = cfg_err_q ? '0 : row_val;
          t_d        = mul_mod(t_q, w_r_q, q_r_q);
          j_d        = '0;
          i_d        = i_q + LOG_N'(1);
          if (i_q == LAST) begin
            state_d = S_FLUSH;
            i_d     = '0;
          end
        end
      end

      S_FLUSH: begin
        busy    = 1'b1;
        k_d     = '0;
        state_d = S_OUTPUT;
      end

      S_OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = res_q[k_q];
        out_last  = (k_q == LAST);
        if (out_ready) begin
          k_d = k_q + LOG_N'(1);
          if (k_q == LAST) begin
            state_d = S_LOAD;
            k_d     = '0;
            j_d     = '0;
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      j_q       <= '0;
      i_q       <= '0;
      k_q       <= '0;
      for (int n = 0; n < N; n++) begin
        a_q[n]   <= '0;
        res_q[n] <= '0;
      end
      q_r_q     <= '0;
      w_r_q     <= '0;
      t_q       <= '0;
      p_q       <= '0;
      acc_q     <= '0;
      cfg_err_q <= 1'b0;
`ifdef NTT_INVERSE_EN
      inv_q     <= 1'b0;
      scale_q   <= 1'b0;
      n_inv_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      i_q       <= i_d;
      k_q       <= k_d;
      a_q       <= a_d;
      res_q     <= res_d;
      q_r_q     <= q_r_d;
      w_r_q     <= w_r_d;
      t_q       <= t_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_d;
`ifdef NTT_INVERSE_EN
      inv_q     <= inv_d;
      scale_q   <= scale_d;
      n_inv_q   <= n_inv_d;
`endif
    end
  end

  assign cfg_err = cfg_err_q;

endmodule
